req_onehot_arbiter: RTL and testbench



---
 rtl/req_onehot_arbiter_pkg.sv | 8 +
 rtl/rr_pick8.sv | 22 ++
 rtl/req_onehot_arbiter.sv | 50 +++++
 tb/tb_req_onehot_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/req_onehot_arbiter_pkg.sv
// req_onehot_arbiter_pkg: shared sizes, reset pointer and state encoding for the arbiter
package req_onehot_arbiter_pkg;
  localparam int NREQ = 8;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] RST_PTR = 3'd7;
  localparam logic IDLE = 1'b0;
  localparam logic GRANT = 1'b1;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational rotate-priority-unrotate picker, lowest set bit at or after start wins
module rr_pick8
  import req_onehot_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  vec,
  input  logic [IDX_W-1:0] start,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  assign dbl = {vec, vec} >> start;
  assign rot = dbl[NREQ-1:0];
  assign any = |vec;
  // descending scan so the lowest rotated position is the final assignment
  always_comb begin
    idx = start;
    for (int i = NREQ-1; i >= 0; i--) if (rot[i]) idx = start + IDX_W'(i);
  end
  assign onehot = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/req_onehot_arbiter.sv
// req_onehot_arbiter: sticky request capture with registered round-robin one-hot grants
module req_onehot_arbiter
  import req_onehot_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_in,
  input  logic            out_ready,
  output logic [NREQ-1:0] onehot_out,
  output logic            out_valid,
  output logic [NREQ-1:0] pending
);
  logic             state, state_nxt;
  logic [IDX_W-1:0] last_ptr, grant_idx, start, pick_idx;
  logic [NREQ-1:0]  space, pick_oh;
  logic             accept, load, pick_any;
  assign accept = state == GRANT && out_valid && out_ready;
  // a fresh request on the accepted bit survives because req_in is OR'd after the clear
  assign space = (pending & ~(accept ? onehot_out : '0)) | req_in;
  assign start = (accept ? grant_idx : last_ptr) + IDX_W'(1);
  assign load = state == IDLE || accept;
  rr_pick8 u_pick (
    .vec    (space),
    .start  (start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = load ? (pick_any ? GRANT : IDLE) : state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      last_ptr   <= RST_PTR;
      grant_idx  <= RST_PTR;
      onehot_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      pending <= space;
      if (accept) last_ptr <= grant_idx;
      if (load) begin
        onehot_out <= pick_oh;
        out_valid  <= pick_any;
        grant_idx  <= pick_idx;
      end
    end
  end
endmodule

// File: tb/tb_req_onehot_arbiter.sv
// tb_req_onehot_arbiter: vector table plus scoreboard queue, with encoder outputs derived from the grant
module tb_req_onehot_arbiter;
  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] oh;
    logic       v;
    logic [7:0] pend;
  } row_t;
  logic       clk = 0, rst = 1, out_ready = 0;
  logic [7:0] req_in = 0, onehot_out, pending;
  logic       out_valid;
  int         n_cmp = 0, n_bad = 0;
  row_t       rows[$];
  row_t       sb[$];
  req_onehot_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .out_ready  (out_ready),
    .onehot_out (onehot_out),
    .out_valid  (out_valid),
    .pending    (pending)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] enc(input logic [7:0] oh);
    return {oh[7] | oh[6] | oh[5] | oh[4], oh[7] | oh[6] | oh[3] | oh[2], oh[7] | oh[5] | oh[3] | oh[1]};
  endfunction
  function automatic logic [2:0] idx_of(input logic [7:0] oh);
    logic [2:0] r = 0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic r, input logic [7:0] q, input logic y, input logic [7:0] oh, input logic v, input logic [7:0] p);
    rows.push_back('{r, q, y, oh, v, p});
  endtask
  initial begin
    row_t e;
    // single request
    add(0, 8'h08, 1, 8'h08, 1, 8'h08);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00);
    // round-robin wrap from a fresh pointer, then re-request with last_ptr=7
    add(1, 8'h00, 0, 8'h00, 0, 8'h00);
    add(0, 8'h81, 1, 8'h01, 1, 8'h81);
    add(0, 8'h00, 1, 8'h80, 1, 8'h80);
    add(0, 8'h81, 1, 8'h01, 1, 8'h81);
    add(0, 8'h00, 1, 8'h80, 1, 8'h80);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00);
    // backpressure: five cycles held at 02
    add(0, 8'h06, 0, 8'h02, 1, 8'h06);
    for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 8'h02, 1, 8'h06);
    add(0, 8'h00, 1, 8'h04, 1, 8'h04);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00);
    // re-request of 10 on its accept goes behind 20 and 01
    add(0, 8'h31, 0, 8'h10, 1, 8'h31);
    add(0, 8'h10, 1, 8'h20, 1, 8'h31);
    add(0, 8'h00, 1, 8'h01, 1, 8'h11);
    add(0, 8'h00, 1, 8'h10, 1, 8'h10);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00);
    // full load
    add(1, 8'h00, 0, 8'h00, 0, 8'h00);
    add(0, 8'hFF, 1, 8'h01, 1, 8'hFF);
    for (int i = 1; i < 8; i++) add(0, 8'h00, 1, 8'h01 << i, 1, 8'hFF << i);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00);
    #1;
    chk("reset_oh", onehot_out, 8'h00);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_pend", pending, 8'h00);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < rows.size(); k++) begin
      @(negedge clk);
      rst = rows[k].rst;
      req_in = rows[k].req;
      out_ready = rows[k].rdy;
      sb.push_back(rows[k]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("oh[%0d]", k), onehot_out, e.oh);
      chk($sformatf("valid[%0d]", k), out_valid, e.v);
      chk($sformatf("pend[%0d]", k), pending, e.pend);
      chk($sformatf("ones[%0d]", k), $countones(onehot_out), e.v ? 1 : 0);
      if (e.v) chk($sformatf("enc[%0d]", k), enc(onehot_out), idx_of(e.oh));
      rst = 0;
    end
    // asynchronous reset with a grant in flight and A5 pending
    @(negedge clk);
    req_in = 8'hA5;
    out_ready = 0;
    @(posedge clk);
    #1;
    chk("pre_rst_oh", onehot_out, 8'h01);
    chk("pre_rst_pend", pending, 8'hA5);
    #2;
    rst = 1;
    #1;
    chk("async_rst_oh", onehot_out, 8'h00);
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_pend", pending, 8'h00);
    @(negedge clk);
    rst = 0;
    req_in = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("post_rst_pend", pending, 8'h00);
    chk("post_rst_valid", out_valid, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
